// File: rtl/lfsr_batch_sequencer.sv
// lfsr_batch_sequencer: runs one LFSR batch (cfg, seed, N steps with stores, average-HD divide and store)
module lfsr_batch_sequencer #(
  parameter int DW  = 8,
  parameter int HDW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-2:0] tap_cfg,
  input  logic [DW-1:0] seed,
  input  logic [DW-1:0] run_len,
  input  logic [DW-1:0] base_addr,
  output logic          cfg_we,
  output logic [DW-2:0] tap_out,
  output logic          seed_load,
  output logic [DW-1:0] seed_out,
  output logic          lfsr_step,
  input  logic [DW-1:0] lfsr_q,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] avg
);
  localparam int CW = $clog2(HDW);
  typedef enum logic [2:0] {IDLE, CFG, SEED, STEP, WRITE, DIV, AVGWR, DONE} state_t;
  state_t state, state_nx;
  logic [DW-1:0] n, base, idx, prev, rem;
  logic [HDW-1:0] hd_total, quo_nx;
  logic [CW-1:0] cnt;
  logic [DW:0] trial;
  logic ge, last;
  // hd_total doubles as the dividend/quotient shift register during DIV
  assign trial = {rem, hd_total[HDW-1]};
  assign ge = trial >= {1'b0, n};
  assign quo_nx = {hd_total[HDW-2:0], ge};
  assign last = cnt == CW'(HDW - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    cfg_we = state == CFG;
    seed_load = state == SEED;
    lfsr_step = state == STEP;
    mem_we = state == WRITE || state == AVGWR;
    mem_addr = state == WRITE ? base + idx : state == AVGWR ? base + n : '0;
    mem_wdata = state == WRITE ? lfsr_q : state == AVGWR ? avg : '0;
    busy = state != IDLE;
    done = state == DONE;
    case (state)
      IDLE:  state_nx = start ? CFG : IDLE;
      CFG:   state_nx = SEED;
      SEED:  state_nx = n == '0 ? DONE : STEP;
      STEP:  state_nx = WRITE;
      WRITE: state_nx = !mem_ready ? WRITE : idx == n - DW'(1) ? DIV : STEP;
      DIV:   state_nx = last ? AVGWR : DIV;
      AVGWR: state_nx = mem_ready ? DONE : AVGWR;
      DONE:  state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tap_out <= '0;
      seed_out <= '0;
      n <= '0;
      base <= '0;
      idx <= '0;
      prev <= '0;
      hd_total <= '0;
      rem <= '0;
      cnt <= '0;
      avg <= '0;
    end else if (!abort) begin
      if (state == IDLE && start) begin
        tap_out <= tap_cfg;
        seed_out <= seed;
        n <= run_len;
        base <= base_addr;
        idx <= '0;
        hd_total <= '0;
        rem <= '0;
        cnt <= '0;
      end
      if (state == SEED) begin
        prev <= seed_out;
        if (n == '0) avg <= '0;
      end
      if (state == WRITE && mem_ready) begin
        hd_total <= hd_total + HDW'($countones(lfsr_q ^ prev));
        prev <= lfsr_q;
        idx <= idx + DW'(1);
      end
      if (state == DIV) begin
        rem <= ge ? DW'(trial - {1'b0, n}) : trial[DW-1:0];
        hd_total <= quo_nx;
        cnt <= cnt + CW'(1);
        if (last) avg <= quo_nx[DW-1:0];
      end
    end
endmodule

// File: tb/tb_lfsr_batch_sequencer.sv
// tb_lfsr_batch_sequencer: directed batches against an LFSR engine model and a write log
module tb_lfsr_batch_sequencer;
  logic clk, reset, start, abort, mem_ready;
  logic [6:0] tap_cfg, tap_out;
  logic [7:0] seed, run_len, base_addr, seed_out, lfsr_q, mem_addr, mem_wdata, avg;
  logic cfg_we, seed_load, lfsr_step, mem_we, busy, done;
  int total = 0, bad = 0;
  int nwr = 0, cfg_n = 0, seed_n = 0, done_n = 0;
  int w0, c0, s0, d0, dc;
  logic [7:0] wa[64], wd[64];
  logic [6:0] etap = '0;
  logic [7:0] q = '0;

  lfsr_batch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .tap_cfg(tap_cfg), .seed(seed), .run_len(run_len), .base_addr(base_addr),
    .cfg_we(cfg_we), .tap_out(tap_out), .seed_load(seed_load), .seed_out(seed_out),
    .lfsr_step(lfsr_step), .lfsr_q(lfsr_q), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .done(done), .avg(avg)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  assign lfsr_q = q;

  function automatic logic [7:0] nxt(input logic [7:0] c, input logic [6:0] t);
    logic [7:0] r;
    r[7] = c[6] ^ (t[0] & c[7]);
    for (int k = 6; k >= 1; k--) r[k] = c[k-1] ^ (t[7-k] & c[7]);
    r[0] = c[7];
    return r;
  endfunction

  always @(posedge clk) begin
    if (cfg_we) etap <= tap_out;
    if (seed_load) q <= seed_out;
    else if (lfsr_step) q <= nxt(q, etap);
    if (mem_we && mem_ready && nwr < 64) begin
      wa[nwr] <= mem_addr;
      wd[nwr] <= mem_wdata;
      nwr <= nwr + 1;
    end
    if (cfg_we) cfg_n <= cfg_n + 1;
    if (seed_load) seed_n <= seed_n + 1;
    if (done) done_n <= done_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input int i, input logic [7:0] a, input logic [7:0] d);
    chk($sformatf("wr%0d_addr", i), wa[w0+i], a);
    chk($sformatf("wr%0d_data", i), wd[w0+i], d);
  endtask

  // done cycle k = the k-th cycle after the accept edge; -1 if not seen within lim
  task automatic run(input logic [6:0] t, input logic [7:0] s, input logic [7:0] n, input logic [7:0] b,
                     input int st0, input int stl, input int ab, input int lim,
                     input logic [7:0] sa, input logic [7:0] sd, output int dcy);
    w0 = nwr; c0 = cfg_n; s0 = seed_n; d0 = done_n;
    @(negedge clk);
    tap_cfg = t; seed = s; run_len = n; base_addr = b; start = 1;
    @(posedge clk); #1;
    start = 0;
    tap_cfg = ~t; seed = ~s; run_len = n + 8'd3; base_addr = b + 8'h40;
    dcy = -1;
    for (int k = 1; k <= lim && dcy < 0; k++) begin
      mem_ready = !(k >= st0 && k < st0 + stl);
      start = k == 5;
      abort = k == ab;
      @(negedge clk);
      if (k >= st0 && k < st0 + stl) begin
        chk("stall_we", mem_we, 1);
        chk("stall_addr", mem_addr, sa);
        chk("stall_data", mem_wdata, sd);
      end
      if (ab > 0 && k == ab + 1) chk("abort_busy", busy, 0);
      if (done) dcy = k;
      @(posedge clk); #1;
    end
    start = 0; abort = 0; mem_ready = 1;
  endtask

  initial begin
    reset = 0; start = 0; abort = 0; mem_ready = 1;
    tap_cfg = '0; seed = '0; run_len = '0; base_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_avg", avg, 0);
    chk("rst_tap_out", tap_out, 0);
    @(negedge clk) reset = 1;

    run(7'h00, 8'h01, 8'd4, 8'h10, 0, 0, 0, 60, 8'h00, 8'h00, dc);
    chk("t1_done_cycle", dc, 23);
    chk("t1_nwr", nwr - w0, 5);
    chkw(0, 8'h10, 8'h02); chkw(1, 8'h11, 8'h04); chkw(2, 8'h12, 8'h08);
    chkw(3, 8'h13, 8'h10); chkw(4, 8'h14, 8'h02);
    chk("t1_avg", avg, 2);
    chk("t1_cfg_pulses", cfg_n - c0, 1);
    chk("t1_seed_pulses", seed_n - s0, 1);

    run(7'h00, 8'h01, 8'd4, 8'h10, 6, 3, 0, 60, 8'h11, 8'h04, dc);
    chk("t2_done_cycle", dc, 26);
    chk("t2_nwr", nwr - w0, 5);
    chkw(0, 8'h10, 8'h02); chkw(1, 8'h11, 8'h04); chkw(2, 8'h12, 8'h08);
    chkw(3, 8'h13, 8'h10); chkw(4, 8'h14, 8'h02);
    chk("t2_avg", avg, 2);

    run(7'h00, 8'h80, 8'd3, 8'hFE, 0, 0, 0, 60, 8'h00, 8'h00, dc);
    chk("t3_done_cycle", dc, 21);
    chk("t3_nwr", nwr - w0, 4);
    chkw(0, 8'hFE, 8'h01); chkw(1, 8'hFF, 8'h02); chkw(2, 8'h00, 8'h04); chkw(3, 8'h01, 8'h02);
    chk("t3_avg", avg, 2);

    run(7'h05, 8'h33, 8'd0, 8'h20, 0, 0, 0, 60, 8'h00, 8'h00, dc);
    chk("t4_done_cycle", dc, 3);
    chk("t4_nwr", nwr - w0, 0);
    chk("t4_avg", avg, 0);
    chk("t4_cfg_pulses", cfg_n - c0, 1);
    chk("t4_seed_pulses", seed_n - s0, 1);

    run(7'h7F, 8'hFF, 8'd1, 8'h40, 0, 0, 0, 60, 8'h00, 8'h00, dc);
    chk("t5_done_cycle", dc, 17);
    chk("t5_nwr", nwr - w0, 2);
    chkw(0, 8'h40, 8'h01); chkw(1, 8'h41, 8'h07);
    chk("t5_avg", avg, 7);

    run(7'h00, 8'h01, 8'd4, 8'h10, 0, 0, 12, 30, 8'h00, 8'h00, dc);
    chk("t6_no_done", dc, -1);
    chk("t6_done_pulses", done_n - d0, 0);
    chk("t6_nwr", nwr - w0, 4);
    chk("t6_avg_kept", avg, 7);
    chk("t6_busy", busy, 0);

    w0 = nwr;
    @(negedge clk);
    tap_cfg = 7'h00; seed = 8'h01; run_len = 8'd4; base_addr = 8'h10; start = 1;
    @(posedge clk); #1;
    start = 0; mem_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("t7_in_write", mem_we, 1);
    #2 reset = 0;
    #1;
    chk("t7_mem_we", mem_we, 0);
    chk("t7_busy", busy, 0);
    chk("t7_avg", avg, 0);
    chk("t7_addr", mem_addr, 0);
    chk("t7_seed_out", seed_out, 0);
    @(negedge clk) reset = 1; mem_ready = 1;
    chk("t7_nwr", nwr - w0, 0);

    run(7'h01, 8'h5A, 8'd0, 8'h00, 0, 0, 0, 60, 8'h00, 8'h00, dc);
    chk("t8_done_cycle", dc, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lfsr_batch_sequencer.md
Name: lfsr_batch_sequencer

Overview:
- Control FSM that sequences the 8-bit tap-configurable LFSR engine through one batch run.
- Configures taps, loads the seed, then steps the engine run_len times.
- Writes each new LFSR state to data memory through a ready-stalled write port and accumulates the Hamming distance between consecutive states.
- Computes the average HD with a sequential divider, stores it after the batch, and replaces per-instruction batch sequencing with a single start/done command.

Parameters:
- DW, 8: LFSR/data/address width.
- HDW, 11: HD accumulator width; must hold 255*8.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin batch; sampled only in IDLE.
- abort  in  1  synchronous abort; overrides everything except reset.
- tap_cfg  in  7  tap mask, latched at start.
- seed  in  8  LFSR seed, latched at start.
- run_len  in  8  number of steps N, latched at start.
- base_addr  in  8  first store address, latched at start.
- cfg_we  out  1  one-cycle pulse; engine loads tap_loc from tap_out.
- tap_out  out  7  latched tap mask, stable while busy.
- seed_load  out  1  one-cycle pulse; engine loads q from seed_out.
- seed_out  out  8  latched seed.
- lfsr_step  out  1  one-cycle pulse; engine shifts once (registered, new q visible next cycle).
- lfsr_q  in  8  engine state.
- mem_we  out  1  write request, held until accepted.
- mem_addr  out  8  write address.
- mem_wdata  out  8  write data.
- mem_ready  in  1  write accepted when mem_we and mem_ready are both high at a clk edge.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on batch completion.
- avg  out  8  last computed average; holds until the next batch's DIV ends.

Behaviour:
- Reset (async, reset low) clears all state:
  - State goes to IDLE.
  - All outputs go to 0, including avg=0.
  - Internal idx, prev, hd_total and divider registers go to 0.
  - This applies mid-batch too; no pending write completes.
- States: IDLE, CFG, SEED, STEP, WRITE, DIV, AVGWR, DONE.
- IDLE:
  - On start=1, latch tap_cfg, seed, run_len and base_addr; clear idx and hd_total; go to CFG.
  - start at any other time is ignored.
- CFG: cfg_we=1 for one cycle; go to SEED.
- SEED:
  - seed_load=1 for one cycle; prev <= seed.
  - If N=0, set avg=0 and go to DONE; no memory writes and no divide.
  - Otherwise go to STEP.
- STEP: lfsr_step=1 for one cycle; go to WRITE.
- WRITE:
  - mem_we=1, mem_addr=(base+idx) mod 256, mem_wdata=lfsr_q.
  - Hold all three until mem_ready=1.
  - On acceptance:
    - hd_total += popcount(lfsr_q ^ prev);
    - prev <= lfsr_q;
    - idx++;
    - if idx == N-1 (pre-increment) go to DIV, else go to STEP.
- DIV:
  - Restoring divide, hd_total (HDW bits) / N, one quotient bit per cycle, exactly HDW=11 cycles.
  - Load avg with the quotient (truncated, ≤8) on the last cycle.
- AVGWR:
  - mem_we=1, mem_addr=(base+N) mod 256, mem_wdata=avg.
  - Held until mem_ready; then go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
- Address wrap: every address is computed mod 256 (8-bit add, carry dropped).
- Latency from the start-accept edge with mem_ready held high, N≥1: CFG 1 + SEED 1 + 2N + DIV 11 + AVGWR 1, then DONE. done is asserted 15+2N cycles after the accept edge.
- mem_ready low stalls only WRITE and AVGWR; no other output changes during a stall.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; mem_we is deasserted immediately at that edge; done is not pulsed.
  - avg retains its previous value.
  - abort together with start in IDLE: abort wins and the batch does not start.
- Input changes on tap_cfg, seed, run_len or base_addr while busy have no effect.
- Engine reference model for the bench:
  - q[7] <= q[6] ^ (tap[0] & q[7]);
  - q[k] <= q[k-1] ^ (tap[7-k] & q[7]) for k=6..1;
  - q[0] <= q[7].

Test Plan:
- tap=0, seed=0x01, N=4, base=0x10, mem_ready=1 -> writes 0x02@0x10, 0x04@0x11, 0x08@0x12, 0x10@0x13, then 0x02@0x14; avg=2; done 23 cycles after accept.
- Same as above with mem_ready low for 3 cycles during the second write -> mem_we/addr/data stay 0x11/0x04 throughout the stall; done arrives 3 cycles later; memory contents identical.
- base=0xFE, N=3, tap=0, seed=0x80 -> writes 0x01@0xFE, 0x02@0xFF, 0x04@0x00; avg=2 written @0x01.
- N=0 -> cfg_we and seed_load each pulse once, no mem_we ever, avg=0, done 3 cycles after accept.
- tap=0x7F, seed=0xFF, N=1 -> write mem_wdata equals the engine-model next state; avg = popcount(0xFF ^ next); verify the HD arithmetic against the model.
- abort asserted during DIV -> busy falls next edge, no done and no AVGWR write, avg keeps its old value. Async reset low mid-WRITE -> all outputs 0 immediately. A start pulse while busy is ignored (no second cfg_we).
